// File: rtl/dm_pipe.sv
// Pipelined data memory for the MEM stage: one load/store per cycle, registered response
// one cycle later, sub-word extension, error flagging and a post-reset zeroing sweep.
module dm_pipe #(
    parameter int DEPTH_LOG2     = 11,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] WData,
    output logic        RespValid,
    output logic [31:0] RData,
    output logic        RespErr,
    output logic        Busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e                state_q;
    logic [DEPTH_LOG2-1:0] clr_cnt_q;
    logic                  ready_q, busy_q;
    logic                  valid_q, err_q, load_ok_q, signed_q;
    logic [1:0]            off_q, size_q;
    logic [31:0]           rd_word_q;
    logic                  valid_d, err_d, load_ok_d;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]            lane_mask;
    logic [31:0]           lane_data;

    assign accept   = ReqValid && ready_q;
    assign word_idx = ReqAddr[DEPTH_LOG2+1:2];

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
        lane_mask = 4'b0000;
        lane_data = WData;
        case (ReqSize)
            2'd0: begin
                lane_mask = 4'b0001 << ReqAddr[1:0];
                lane_data = {4{WData[7:0]}};
            end
            2'd1: begin
                lane_mask = 4'b0011 << ReqAddr[1:0];
                lane_data = {2{WData[15:0]}};
            end
            2'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    assign req_err = (ReqSize == 2'd3)
                  || (ReqSize == 2'd1 && ReqAddr[0])
                  || (ReqSize == 2'd2 && ReqAddr[1:0] != 2'b00)
                  || (|ReqAddr[31:DEPTH_LOG2+2]);

    assign valid_d   = accept;
    assign err_d     = req_err;
    assign load_ok_d = !ReqWrite && !req_err;

    // NOTE: the array has no reset; it is cleared by the sweep instead, which keeps it a plain RAM.
    always_ff @(posedge Clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (accept && ReqWrite && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
        if (accept) rd_word_q <= mem[word_idx];
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= CLEAR_ON_RESET;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == {DEPTH_LOG2{1'b1}}) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase

            valid_q <= valid_d;
            if (accept) begin
                err_q     <= err_d;
                load_ok_q <= load_ok_d;
                off_q     <= ReqAddr[1:0];
                size_q    <= ReqSize;
                signed_q  <= ReqSigned;
            end
        end
    end

    logic [31:0] shifted, extended;

    always_comb begin
        shifted = rd_word_q >> {off_q, 3'b000};
        case (size_q)
            2'd0:    extended = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'd1:    extended = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: extended = rd_word_q;
        endcase
    end

    // Response fields change only at acceptance, so they hold while RespValid is low.
    assign RData     = load_ok_q ? extended : 32'h0;
    assign RespErr   = err_q;
    assign RespValid = valid_q;
    assign ReqReady  = ready_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_dm_pipe.sv
// Self-checking bench for dm_pipe: directed plan items plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_dm_pipe;
    localparam int DL2   = 4;
    localparam int BYTES = 4 << DL2;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        ReqValid = 1'b0, ReqWrite = 1'b0, ReqSigned = 1'b0;
    logic [31:0] ReqAddr = '0, WData = '0;
    logic [1:0]  ReqSize = '0;
    logic        ReqReady, RespValid, RespErr, Busy;
    logic [31:0] RData;

    dm_pipe #(.DEPTH_LOG2(DL2), .CLEAR_ON_RESET(1'b1)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqSize(ReqSize),
        .ReqSigned(ReqSigned), .WData(WData), .RespValid(RespValid),
        .RData(RData), .RespErr(RespErr), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mem_m [BYTES];
    logic [31:0] last_data;
    logic        last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
        int n = 1 << sz;
        return (sz == 2'd3) || ((a % n) != 0) || (a >= BYTES);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input bit sg);
        int n = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[a+i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;
    endtask

    // Issues one request, waits for its edge and checks the response against the model.
    task automatic do_req(input bit w, input logic [31:0] a, input logic [1:0] sz,
                          input bit sg, input logic [31:0] wd, output logic [31:0] got);
        bit          e_err = model_err(a, sz);
        logic [31:0] e_dat = (w || e_err) ? 32'h0 : model_load(a, sz, sg);
        ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqSize = sz; ReqSigned = sg; WData = wd;
        @(posedge Clk); #1;
        check("resp_valid", {31'b0, RespValid}, 32'd1);
        check("resp_err",   {31'b0, RespErr},   {31'b0, e_err});
        check("rdata",      RData, e_dat);
        got = RData;
        last_data = RData;
        last_err  = RespErr;
        if (w && !e_err) begin
            int n = 1 << sz;
            for (int i = 0; i < n; i++) mem_m[a+i] = 8'(wd >> (8*i));
        end
    endtask

    task automatic idle();
        ReqValid = 1'b0;
        @(posedge Clk); #1;
        check("idle_valid", {31'b0, RespValid}, 32'd0);
        check("idle_hold",  RData, last_data);
        check("idle_err",   {31'b0, RespErr}, {31'b0, last_err});
    endtask

    // Counts edges from release until ReqReady rises; RespValid must stay low throughout.
    task automatic wait_sweep(input string tag);
        int n = 0;
        int stray = 0;
        while (ReqReady !== 1'b1 && n <= 100) begin
            @(posedge Clk); #1;
            n++;
            if (RespValid !== 1'b0) stray++;
            if (ReqReady !== 1'b1 && Busy !== 1'b1) stray++;
        end
        check({tag, "_len"}, n, 16);
        check({tag, "_stray"}, stray, 0);
        check({tag, "_busy_done"}, {31'b0, Busy}, 32'd0);
    endtask

    logic [31:0] got;

    initial begin
        model_clear();
        last_data = '0;
        last_err  = 1'b0;

        // Reset state
        #12;
        check("rst_ready", {31'b0, ReqReady}, 32'd0);
        check("rst_valid", {31'b0, RespValid}, 32'd0);
        check("rst_rdata", RData, 32'd0);
        check("rst_err",   {31'b0, RespErr}, 32'd0);
        check("rst_busy",  {31'b0, Busy}, 32'd1);

        // Mid-sweep reset, then a full sweep
        Rst_n = 1'b1;
        repeat (5) @(posedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        check("midsweep_busy",  {31'b0, Busy}, 32'd1);
        check("midsweep_ready", {31'b0, ReqReady}, 32'd0);
        @(posedge Clk); #1 Rst_n = 1'b1;
        wait_sweep("sweep");

        for (int a = 0; a < BYTES; a += 4) do_req(1'b0, a, 2'd2, 1'b0, 0, got);
        idle();

        // Word and sub-word stores
        do_req(1'b1, 32'h8, 2'd2, 1'b0, 32'h1122_3344, got);
        do_req(1'b1, 32'h9, 2'd0, 1'b0, 32'hFFFF_FFAB, got);
        do_req(1'b1, 32'hA, 2'd1, 1'b0, 32'h1234_BEEF, got);
        do_req(1'b0, 32'h8, 2'd2, 1'b0, 0, got);
        check("plan_word", got, 32'hBEEF_AB44);

        // Extension
        do_req(1'b0, 32'h9, 2'd0, 1'b1, 0, got);
        check("plan_sbyte", got, 32'hFFFF_FFAB);
        do_req(1'b0, 32'h9, 2'd0, 1'b0, 0, got);
        check("plan_ubyte", got, 32'h0000_00AB);
        do_req(1'b0, 32'hA, 2'd1, 1'b1, 0, got);
        check("plan_shalf", got, 32'hFFFF_BEEF);
        idle();

        // Errors leave memory unchanged
        do_req(1'b0, 32'h6, 2'd2, 1'b0, 0, got);
        do_req(1'b1, 32'h3, 2'd1, 1'b0, 32'hDEAD_BEEF, got);
        do_req(1'b1, 32'h8, 2'd3, 1'b0, 32'hDEAD_BEEF, got);
        do_req(1'b1, BYTES, 2'd2, 1'b0, 32'hDEAD_BEEF, got);
        do_req(1'b1, 32'h0010_0008, 2'd2, 1'b0, 32'hDEAD_BEEF, got);
        do_req(1'b0, 32'h0, 2'd2, 1'b0, 0, got);
        do_req(1'b0, 32'h8, 2'd2, 1'b0, 0, got);
        check("err_unchanged", got, 32'hBEEF_AB44);

        // Back-to-back read-after-write
        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'h5, got);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 0, got);
        check("b2b_raw", got, 32'h5);
        idle();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit          w  = 1'($urandom_range(0, 1));
            logic [1:0]  sz = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
            logic [31:0] a  = ($urandom_range(0, 15) == 0) ? 32'($urandom)
                                                           : 32'($urandom_range(0, BYTES + 7));
            do_req(w, a, sz, 1'($urandom_range(0, 1)), $urandom, got);
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();

        // Reset with a load in flight
        do_req(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFE_F00D, got);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 32'h20; ReqSize = 2'd2;
        @(posedge Clk); #1;
        check("inflight_valid", {31'b0, RespValid}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check("inflight_drop",  {31'b0, RespValid}, 32'd0);
        check("inflight_rdata", RData, 32'd0);
        check("inflight_err",   {31'b0, RespErr}, 32'd0);
        ReqValid = 1'b0;
        @(posedge Clk); #1 Rst_n = 1'b1;
        model_clear();
        last_data = '0;
        last_err  = 1'b0;
        wait_sweep("resweep");
        do_req(1'b0, 32'h20, 2'd2, 1'b0, 0, got);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
